// File: rtl/dmac_ioregister_pkg.sv
// Shared types and elaboration helpers for the DMAC I/O register bank.
package dmac_ioregister_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Number of address bits that select a byte within one data word.
   function automatic int byte_off_width(input int w_d);
      return clog2(w_d / 8);
   endfunction

endpackage

// File: rtl/dmac_ioregister_file.sv
// Register storage with a byte-strobed bus write port, a full-word control
// write port, two async read ports and sticky per-register bus-write flags.
module dmac_ioregister_file
   import dmac_ioregister_pkg::*;
#(
   parameter int W_D      = 32,
   parameter int NUM_REGS = 8,
   parameter int W_RA     = clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bus_we,
   input  logic [W_RA-1:0]     bus_idx,
   input  logic [W_D-1:0]      bus_wdata,
   input  logic [W_D/8-1:0]    bus_strb,
   input  logic                ctl_we,
   input  logic [W_RA-1:0]     ctl_idx,
   input  logic [W_D-1:0]      ctl_wdata,
   input  logic [W_RA-1:0]     rd_a_idx,
   output logic [W_D-1:0]      rd_a_data,
   input  logic [W_RA-1:0]     rd_b_idx,
   output logic [W_D-1:0]      rd_b_data,
   output logic [NUM_REGS-1:0] flags
);

   localparam int NB = W_D / 8;

   logic [W_D-1:0]      regs_q [NUM_REGS];
   logic [W_D-1:0]      regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] flags_q;
   logic [NUM_REGS-1:0] flags_d;

   // Bus port is applied after the control port so strobed bus bytes and the
   // flag set take precedence on a same-register collision.
   always_comb begin
      flags_d = flags_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         if (ctl_we && ctl_idx == W_RA'(r)) begin
            regs_d[r]  = ctl_wdata;
            flags_d[r] = 1'b0;
         end
         if (bus_we && bus_idx == W_RA'(r)) begin
            for (int b = 0; b < NB; b++) begin
               if (bus_strb[b]) regs_d[r][8*b +: 8] = bus_wdata[8*b +: 8];
            end
            flags_d[r] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         flags_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
         flags_q <= flags_d;
      end
   end

   assign rd_a_data = regs_q[rd_a_idx];
   assign rd_b_data = regs_q[rd_b_idx];
   assign flags     = flags_q;

endmodule

// File: rtl/dmac_ioregister_bank.sv
// Register bank with an AXI-like burst slave for the DMA master and a
// single-cycle random-access port for the control thread.
//
// state    | meaning
// ST_IDLE  | waiting for a write or read command (write has priority)
// ST_WRITE | accepting write beats until the beat count runs out
// ST_READ  | presenting read beats until the beat count runs out
module dmac_ioregister_bank
   import dmac_ioregister_pkg::*;
#(
   parameter int W_D      = 32,
   parameter int W_EXT_A  = 32,
   parameter int W_BLEN   = 8,
   parameter int NUM_REGS = 8,
   parameter int W_RA     = clog2(NUM_REGS)
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic [W_RA-1:0]     coram_addr,
   input  logic [W_D-1:0]      coram_d,
   input  logic                coram_we,
   output logic [W_D-1:0]      coram_q,
   output logic [NUM_REGS-1:0] bus_written,
   input  logic                awvalid,
   input  logic [W_EXT_A-1:0]  awaddr,
   input  logic [W_BLEN-1:0]   awlen,
   output logic                awready,
   input  logic                wvalid,
   input  logic [W_D-1:0]      wdata,
   input  logic [W_D/8-1:0]    wstrb,
   input  logic                wlast,
   output logic                wready,
   input  logic                arvalid,
   input  logic [W_EXT_A-1:0]  araddr,
   input  logic [W_BLEN-1:0]   arlen,
   output logic                arready,
   output logic                rvalid,
   output logic [W_D-1:0]      rdata,
   output logic                rlast,
   input  logic                rready
);

   localparam int BOFF = byte_off_width(W_D);
   localparam logic [W_BLEN:0] CNT_ONE = (W_BLEN+1)'(1);

   state_e          state_q, state_d;
   logic [W_RA-1:0] idx_q, idx_d;
   logic [W_BLEN:0] cnt_q, cnt_d;
   logic            awready_q, awready_d;
   logic            arready_q, arready_d;
   logic            rvalid_q, rvalid_d;
   logic [W_D-1:0]  rdata_q, rdata_d;
   logic [W_D-1:0]  coram_rd_q;

   logic [W_RA-1:0] aw_idx, ar_idx, idx_inc, rd_b_idx;
   logic [W_D-1:0]  rd_a_data, rd_b_data;
   logic            bus_we;
   logic            wlast_unused;

   assign aw_idx   = awaddr[BOFF +: W_RA];
   assign ar_idx   = araddr[BOFF +: W_RA];
   assign idx_inc  = idx_q + W_RA'(1);
   assign bus_we   = (state_q == ST_WRITE) && wvalid;
   // In IDLE the read port fetches the first beat; in READ it prefetches the next.
   assign rd_b_idx = (state_q == ST_IDLE) ? ar_idx : idx_inc;
   assign wlast_unused = wlast;

   dmac_ioregister_file #(
      .W_D      (W_D),
      .NUM_REGS (NUM_REGS),
      .W_RA     (W_RA)
   ) u_file (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .bus_we    (bus_we),
      .bus_idx   (idx_q),
      .bus_wdata (wdata),
      .bus_strb  (wstrb),
      .ctl_we    (coram_we),
      .ctl_idx   (coram_addr),
      .ctl_wdata (coram_d),
      .rd_a_idx  (coram_addr),
      .rd_a_data (rd_a_data),
      .rd_b_idx  (rd_b_idx),
      .rd_b_data (rd_b_data),
      .flags     (bus_written)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      awready_d = 1'b0;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (awvalid) begin
               idx_d     = aw_idx;
               cnt_d     = {1'b0, awlen} + CNT_ONE;
               awready_d = 1'b1;
               state_d   = ST_WRITE;
            end else if (arvalid) begin
               idx_d     = ar_idx;
               cnt_d     = {1'b0, arlen} + CNT_ONE;
               arready_d = 1'b1;
               rvalid_d  = 1'b1;
               rdata_d   = rd_b_data;
               state_d   = ST_READ;
            end
         end
         ST_WRITE: begin
            if (wvalid) begin
               idx_d = idx_inc;
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rvalid_q && rready) begin
               idx_d = idx_inc;
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  rvalid_d = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  rdata_d = rd_b_data;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         awready_q  <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         coram_rd_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         awready_q  <= awready_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         coram_rd_q <= rd_a_data;
      end
   end

   assign coram_q = coram_rd_q;
   assign awready = awready_q;
   assign arready = arready_q;
   assign wready  = (state_q == ST_WRITE);
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rlast   = rvalid_q && (cnt_q == CNT_ONE);

endmodule

// File: doc/dmac_ioregister_bank.md
# dmac_ioregister_bank

Parametrised successor to the single-word DMAC I/O register. It provides a bank of `NUM_REGS` word registers. The DMA bus side accesses the bank through an AXI-like burst slave, with per-beat address increment, byte strobes and wrap-around inside the bank. A single-cycle random-access port serves the control thread, and a per-register "written by bus" flag vector signals the control thread. It sits between the DMA master and control-thread logic, entirely in the `ACLK` domain.

## Interface
- `W_D`, 32: data width; power of 2, at least 8.
- `W_EXT_A`, 32: bus byte-address width.
- `W_BLEN`, 8: burst-length field width (beats = len+1).
- `NUM_REGS`, 8: register count; power of 2, at least 2.
- `W_RA`, log2(`NUM_REGS`): register index width (derived).
- `ACLK` in 1: clock.
- `ARESETN` in 1: synchronous active-low reset.
- `coram_addr` in `W_RA`: control-thread register index.
- `coram_d` in `W_D`: control-thread write data.
- `coram_we` in 1: control-thread full-word write strobe.
- `coram_q` out `W_D`: registered read of `reg[coram_addr]`.
- `bus_written` out `NUM_REGS`: sticky per-register bus-write flags.
- `awvalid` in 1, `awaddr` in `W_EXT_A`, `awlen` in `W_BLEN`, `awready` out 1: write command.
- `wvalid` in 1, `wdata` in `W_D`, `wstrb` in `W_D/8`, `wlast` in 1, `wready` out 1: write data.
- `arvalid` in 1, `araddr` in `W_EXT_A`, `arlen` in `W_BLEN`, `arready` out 1: read command.
- `rvalid` out 1, `rdata` out `W_D`, `rlast` out 1, `rready` in 1: read data.

## Operation
- Register index from address: `addr[log2(W_D/8) +: W_RA]`. Low byte-offset bits are ignored; upper bits are ignored, so the bank aliases.
- FSM states are IDLE, WRITE and READ.
- **IDLE**
  - If `awvalid` is high: latch index and beat count `awlen+1` (width `W_BLEN+1`), pulse `awready` for 1 cycle, go to WRITE.
  - Else if `arvalid` is high: latch index and count `arlen+1`, pulse `arready` for 1 cycle, go to READ.
  - Write has priority when both commands are valid.
- **WRITE**
  - `wready` = 1.
  - Each beat (`wvalid && wready`) does three things:
    - writes the bytes of `reg[idx]` whose `wstrb` bit is set;
    - sets `bus_written[idx]`;
    - advances `idx` by 1 modulo `NUM_REGS`, so bursts wrap.
  - The count decrements each beat. After the final beat, go to IDLE.
  - `wlast` is ignored; completion is count-based. There is no write-response channel.
- **READ**
  - Beat data is loaded into `rdata` from `reg[idx]` and presented with `rvalid` = 1.
  - On `rvalid && rready`: count decrements, `idx` advances modulo `NUM_REGS`, and the next word loads into `rdata` the same edge.
  - After the final accepted beat, `rvalid` drops and the FSM goes to IDLE.
  - `rlast` = `rvalid && (count == 1)`.
  - `rdata` and `rlast` hold stable while `rvalid && !rready`.
- **Control port**
  - `coram_q <= reg[coram_addr]` every cycle, read-before-write: a same-cycle `coram_we` shows the old value.
  - `coram_we` writes `coram_d` to `reg[coram_addr]` and clears `bus_written[coram_addr]`.
- **Conflicts**
  - Same-cycle bus beat and `coram_we` to the same register: strobed bus bytes win, unstrobed bytes take `coram_d`.
  - The flag set wins over clear.
  - Writes to different registers both take effect.
- **READ staleness:** `rdata` reflects the register contents at the load edge. A later write to an already-loaded beat is not reflected.

## Timing
- **Reset (`ARESETN` = 0 at an edge):** FSM to IDLE; all registers, `bus_written`, `coram_q`, `rdata`, counters and indices go to 0; `awready`, `arready`, `wready`, `rvalid` and `rlast` go to 0.
- **Reset mid-burst:** the burst is abandoned with no further beats, and all state is cleared.
- **Command acceptance:** `awvalid`/`arvalid` sampled at edge N produces `awready`/`arready` high in cycle N+1.
  - Write: `wready` high from cycle N+1.
  - Read: first `rvalid` in cycle N+1.
- **Next command:** after the last beat at edge M, the FSM is IDLE in cycle M+1, and a new command can be accepted at edge M+1.
- **Throughput:** 1 beat/cycle in both directions when the peer does not stall.
- **Control port latency:**
  - `coram_q` read: 1 cycle.
  - Write visible on `coram_q` the cycle after the write edge.
  - `bus_written` set visible the cycle after the beat.
- **`awlen` = 0:** single beat; `rlast` high on the first read beat.

## Structure
- Shared package `dmac_ioregister_pkg`:
  - FSM state enum (IDLE, WRITE, READ);
  - a `clog2` function;
  - a helper that extracts the byte-offset width from `W_D`.
- Sub-module `dmac_ioregister_file`: holds `NUM_REGS` × `W_D` with two write ports (byte-strobed bus port and full-word control port, with the merge rule above), two async read ports and the flag vector.
- The top level contains the FSM, counters, index and output registers.

## Test plan
- Reset, then control writes `0x11111111`…`0x88888888` to regs 0–7. Read back via `coram_q` with 1-cycle latency, and all `bus_written` = 0.
- Bus write `awaddr=0x18`, `awlen=3`, `wstrb=0xF`, data A–D: regs 6, 7, 0, 1 updated (wrap), and `bus_written=0xC3`.
- Bus write `wstrb=0x5`, data `0xAABBCCDD` to reg 2, which holds `0x33333333`: reg 2 becomes `0x33BB33DD`.
- Bus read `araddr=0x1C`, `arlen=2`, with `rready` toggling 1, 0, 0, 1, 1:
  - returns regs 7, 0, 1;
  - `rdata` is stable while stalled;
  - `rlast` is high only on the third beat.
- Same-cycle bus beat (`wstrb=0x3`, `0x0000BEEF`) and `coram_we` (`0x12345678`) to reg 4: reg 4 = `0x1234BEEF` and `bus_written[4]` = 1.
- `awvalid` and `arvalid` raised together: write is served first and read is accepted right after. `ARESETN` pulsed mid-read-burst: `rvalid` = 0 next cycle and the bank is zeroed.
